spongent_feed_adapter: RTL and testbench
========================================

SPONGENT_FEED_ADAPTER -- requirements
Module: spongent_feed_adapter

Interface
REQ-001 Parameter RATE, default 16, sponge rate in bits; SHALL divide 32.
REQ-002 Parameter HASH_SIZE, default 160, digest width in bits.
REQ-003 Parameter TIMEOUT, default 65535, max cycles waited for core_done.
REQ-004 Port clk  in  1  sole clock, all logic on rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port feed_valid  in  1  one-cycle strobe: feed_data holds a message word.
REQ-007 Port feed_data  in  32  message word, MSB-first bit order.
REQ-008 Port stop_feed  in  1  one-cycle strobe: no further words; pad and finalize.
REQ-009 Port busy  out  1  high while a word or finalization is in progress.
REQ-010 Port end_o  out  1  digest valid; sticky until rst.
REQ-011 Port err  out  1  protocol or timeout error; sticky until rst.
REQ-012 Port block_o  out  RATE  rate block to hash core.
REQ-013 Port block_valid  out  1  block_o valid, held until accepted.
REQ-014 Port block_last  out  1  qualifies the padding block, the final block.
REQ-015 Port core_ready  in  1  core accepts block when block_valid and core_ready are both high.
REQ-016 Port core_done  in  1  one-cycle strobe: core_hash valid.
REQ-017 Port core_hash  in  HASH_SIZE  digest from core.
REQ-018 Port hash_o  out  HASH_SIZE  registered digest.

Function
REQ-019 FSM states: WAIT_WORD, SEND, PAD, WAIT_HASH, DONE, ERROR.
REQ-020 WAIT_WORD: busy=0; feed_valid latches feed_data into a shift register, clears the chunk counter, next state SEND.
REQ-021 SEND: block_o = top RATE bits of the shift register; block_valid=1, block_last=0.
REQ-022 SEND: each accepted transfer shifts the register left by RATE; after 32/RATE transfers the next state is WAIT_WORD, or PAD if a stop is pending.
REQ-023 Latency: feed_valid in cycle t gives block_valid=1 in t+1; busy=1 from t+1 until the cycle after the last accepted chunk.
REQ-024 stop_feed in WAIT_WORD: next state PAD; stop_feed together with feed_valid: the word is sent first, then PAD.
REQ-025 stop_feed while in SEND: sets the pending-stop flag; it is not an error.
REQ-026 PAD: block_o = 1 followed by RATE-1 zeros (RATE=16 gives 16'h8000); block_valid=1, block_last=1; on acceptance go to WAIT_HASH.
REQ-027 Stop with no words sent: only the padding block is issued (empty message).
REQ-028 WAIT_HASH: a cycle counter increments each cycle.
REQ-029 WAIT_HASH: core_done latches core_hash into hash_o and moves to DONE.
REQ-030 WAIT_HASH: the counter reaching TIMEOUT moves to ERROR.
REQ-031 DONE: end_o=1, busy=0; further feed_valid or stop_feed are ignored.
REQ-032 feed_valid while busy=1, or core_done outside WAIT_HASH: go to ERROR, err=1.
REQ-033 ERROR: block_valid=0, busy=0; held until rst.
REQ-034 block_o and block_last SHALL stay stable while block_valid=1 and core_ready=0.

Reset
REQ-035 rst high at any edge, including mid-transfer, forces WAIT_WORD and clears the shift register, counters and pending stop.
REQ-036 rst also drives busy=0, end_o=0, err=0, block_valid=0, block_last=0, block_o=0, hash_o=0 on the next edge.

Structure
REQ-037 Package spongent_feed_pkg SHALL hold the state enum, WORD_SIZE=32 and the padding-pattern function of RATE.
REQ-038 Single module; no sub-module is required.

Verification (RATE=16, HASH_SIZE=160, core_ready tied 1 unless stated)
REQ-039 feed 32'hDEADBEEF then stop_feed -> blocks 16'hDEAD, 16'hBEEF, then 16'h8000 with block_last=1; core_done with hash X -> hash_o=X, end_o=1.
REQ-040 stop_feed only -> single block 16'h8000 with block_last=1, no other blocks.
REQ-041 core_ready low for 5 cycles during 16'hDEAD -> block_o held stable at 16'hDEAD; no chunk lost or duplicated.
REQ-042 feed_valid in the cycle after an accepted word -> err=1, block_valid=0 from the next cycle.
REQ-043 TIMEOUT=10, no core_done -> err=1 exactly 10 cycles after entering WAIT_HASH.
REQ-044 rst asserted between the two chunks -> all outputs zero; a new 32'h01234567 word yields 16'h0123 first.

Source files
------------

// File: rtl/spongent_feed_pkg.sv
// Shared types and constants for the SPONGENT message feed adapter.
// The padding helper returns the 1-then-zeros pattern right-aligned to a rate width.
package spongent_feed_pkg;

    localparam int WORD_SIZE = 32;

    typedef enum logic [2:0] {
        WAIT_WORD = 3'd0,
        SEND      = 3'd1,
        PAD       = 3'd2,
        WAIT_HASH = 3'd3,
        DONE      = 3'd4,
        ERROR     = 3'd5
    } state_e;

    function automatic logic [WORD_SIZE-1:0] pad_pattern(input int rate);
        logic [WORD_SIZE-1:0] p;
        p = '0;
        p[rate-1] = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/spongent_feed_adapter.sv
// Splits 32-bit message words into RATE-bit blocks for a SPONGENT core, appends the
// padding block on stop, and captures the digest with a bounded wait for core_done.
module spongent_feed_adapter
    import spongent_feed_pkg::*;
#(
    parameter int RATE      = 16,
    parameter int HASH_SIZE = 160,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 feed_valid,
    input  logic [31:0]          feed_data,
    input  logic                 stop_feed,
    output logic                 busy,
    output logic                 end_o,
    output logic                 err,
    output logic [RATE-1:0]      block_o,
    output logic                 block_valid,
    output logic                 block_last,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic [HASH_SIZE-1:0] core_hash,
    output logic [HASH_SIZE-1:0] hash_o
);

    localparam int CHUNKS = WORD_SIZE / RATE;
    localparam int CH_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [WORD_SIZE-1:0] PAD_WORD  = pad_pattern(RATE);
    localparam logic [RATE-1:0]      PAD_BLOCK = PAD_WORD[RATE-1:0];

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   shreg_q, shreg_d;
    logic [CH_W-1:0]        chunk_q, chunk_d;
    logic                   stop_q, stop_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HASH_SIZE-1:0]   hash_q, hash_d;
    logic                   accept;

    // Outputs decode directly from the state so a reset clears them on the same edge.
    assign block_valid = (state_q == SEND) || (state_q == PAD);
    assign block_last  = (state_q == PAD);
    assign busy        = (state_q == SEND) || (state_q == PAD) || (state_q == WAIT_HASH);
    assign end_o       = (state_q == DONE);
    assign err         = (state_q == ERROR);
    assign hash_o      = hash_q;
    assign accept      = block_valid && core_ready;

    always_comb begin
        block_o = '0;
        if (state_q == SEND) begin
            block_o = shreg_q[WORD_SIZE-1 -: RATE];
        end else if (state_q == PAD) begin
            block_o = PAD_BLOCK;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        chunk_d = chunk_q;
        stop_d  = stop_q;
        cnt_d   = cnt_q;
        hash_d  = hash_q;
        unique case (state_q)
            WAIT_WORD: begin
                if (core_done) begin
                    state_d = ERROR;
                end else if (feed_valid) begin
                    shreg_d = feed_data;
                    chunk_d = '0;
                    stop_d  = stop_feed;
                    state_d = SEND;
                end else if (stop_feed) begin
                    state_d = PAD;
                end
            end
            SEND: begin
                if (feed_valid || core_done) begin
                    state_d = ERROR;
                end else begin
                    if (stop_feed) begin
                        stop_d = 1'b1;
                    end
                    if (accept) begin
                        shreg_d = shreg_q << RATE;
                        chunk_d = chunk_q + CH_W'(1);
                        if (chunk_q == CH_W'(CHUNKS - 1)) begin
                            state_d = (stop_q || stop_feed) ? PAD : WAIT_WORD;
                            stop_d  = 1'b0;
                        end
                    end
                end
            end
            PAD: begin
                if (feed_valid || core_done) begin
                    state_d = ERROR;
                end else if (accept) begin
                    cnt_d   = '0;
                    state_d = WAIT_HASH;
                end
            end
            WAIT_HASH: begin
                if (feed_valid) begin
                    state_d = ERROR;
                end else if (core_done) begin
                    hash_d  = core_hash;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d = ERROR;
                    end
                end
            end
            DONE: begin
                // A stray digest after completion is a protocol violation; feed/stop are not.
                if (core_done) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_WORD;
            shreg_q <= '0;
            chunk_q <= '0;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            chunk_q <= chunk_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
            hash_q  <= hash_d;
        end
    end

endmodule

// File: tb/tb_spongent_feed_adapter.sv
// Directed bench for spongent_feed_adapter at RATE=16, HASH_SIZE=160, TIMEOUT=10.
module tb_spongent_feed_adapter;

    localparam int RATE      = 16;
    localparam int HASH_SIZE = 160;
    localparam int TIMEOUT   = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 feed_valid = 1'b0;
    logic [31:0]          feed_data = '0;
    logic                 stop_feed = 1'b0;
    logic                 busy, end_o, err, block_valid, block_last;
    logic [RATE-1:0]      block_o;
    logic                 core_ready = 1'b1;
    logic                 core_done = 1'b0;
    logic [HASH_SIZE-1:0] core_hash = '0;
    logic [HASH_SIZE-1:0] hash_o;

    int total = 0;
    int bad   = 0;

    localparam logic [HASH_SIZE-1:0] HASH_X =
        160'h0123456789ABCDEF_FEDCBA9876543210_A5A5C3C3;

    spongent_feed_adapter #(
        .RATE(RATE), .HASH_SIZE(HASH_SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .feed_valid(feed_valid), .feed_data(feed_data), .stop_feed(stop_feed),
        .busy(busy), .end_o(end_o), .err(err),
        .block_o(block_o), .block_valid(block_valid), .block_last(block_last),
        .core_ready(core_ready), .core_done(core_done), .core_hash(core_hash),
        .hash_o(hash_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [HASH_SIZE-1:0] got,
                       input logic [HASH_SIZE-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; feed_valid = 1'b0; stop_feed = 1'b0; core_done = 1'b0; core_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);       chk("rst_end", end_o, 0);
        chk("rst_err", err, 0);         chk("rst_bv", block_valid, 0);
        chk("rst_bl", block_last, 0);   chk("rst_blk", block_o, 0);
        chk("rst_hash", hash_o, 0);

        // DEADBEEF with stop in the same cycle, then digest
        feed_valid = 1'b1; feed_data = 32'hDEADBEEF; stop_feed = 1'b1;
        chk("idle_busy", busy, 0);
        step();
        feed_valid = 1'b0; stop_feed = 1'b0;
        chk("w1_blk0", block_o, 16'hDEAD); chk("w1_bv0", block_valid, 1);
        chk("w1_bl0", block_last, 0);      chk("w1_busy", busy, 1);
        step();
        chk("w1_blk1", block_o, 16'hBEEF); chk("w1_bl1", block_last, 0);
        step();
        chk("w1_pad", block_o, 16'h8000);  chk("w1_padlast", block_last, 1);
        chk("w1_padbv", block_valid, 1);
        step();
        chk("w1_wh_bv", block_valid, 0);   chk("w1_wh_busy", busy, 1);
        core_done = 1'b1; core_hash = HASH_X;
        step();
        core_done = 1'b0; core_hash = '0;
        chk("w1_hash", hash_o, HASH_X);    chk("w1_end", end_o, 1);
        chk("w1_done_busy", busy, 0);
        feed_valid = 1'b1; feed_data = 32'h11111111; stop_feed = 1'b1;
        step();
        feed_valid = 1'b0; stop_feed = 1'b0;
        chk("done_ign_err", err, 0);       chk("done_ign_end", end_o, 1);
        chk("done_ign_bv", block_valid, 0);

        // Empty message: only the padding block
        do_reset();
        chk("e_end_clr", end_o, 0);        chk("e_hash_clr", hash_o, 0);
        stop_feed = 1'b1;
        step();
        stop_feed = 1'b0;
        chk("e_pad", block_o, 16'h8000);   chk("e_last", block_last, 1);
        step();
        chk("e_bv_after", block_valid, 0); chk("e_busy", busy, 1);

        // Back-pressure holds the first chunk stable
        do_reset();
        core_ready = 1'b0;
        feed_valid = 1'b1; feed_data = 32'hDEADBEEF;
        step();
        feed_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), block_o, 16'hDEAD);
            chk($sformatf("bp_bv%0d", i), block_valid, 1);
            step();
        end
        core_ready = 1'b1;
        chk("bp_still", block_o, 16'hDEAD);
        step();
        chk("bp_next", block_o, 16'hBEEF);
        step();
        chk("bp_idle_bv", block_valid, 0); chk("bp_idle_busy", busy, 0);
        chk("bp_idle_err", err, 0);

        // stop_feed mid-word is remembered, not an error
        do_reset();
        feed_valid = 1'b1; feed_data = 32'h11112222;
        step();
        feed_valid = 1'b0; stop_feed = 1'b1;
        chk("ms_blk0", block_o, 16'h1111);
        step();
        stop_feed = 1'b0;
        chk("ms_blk1", block_o, 16'h2222); chk("ms_err", err, 0);
        step();
        chk("ms_pad", block_o, 16'h8000);  chk("ms_last", block_last, 1);

        // feed_valid while busy -> ERROR
        do_reset();
        feed_valid = 1'b1; feed_data = 32'hCAFEF00D;
        step();
        feed_valid = 1'b1;
        step();
        feed_valid = 1'b0;
        chk("ov_err", err, 1);             chk("ov_bv", block_valid, 0);
        chk("ov_busy", busy, 0);
        step(); step();
        chk("ov_sticky", err, 1);

        // Timeout: err exactly TIMEOUT cycles after entering WAIT_HASH
        do_reset();
        stop_feed = 1'b1;
        step();
        stop_feed = 1'b0;
        step();
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            if (i == TIMEOUT - 1) chk("to_early", err, 0);
        end
        step();
        chk("to_err", err, 1);             chk("to_busy", busy, 0);

        // Reset between chunks, then a fresh word
        do_reset();
        feed_valid = 1'b1; feed_data = 32'hDEADBEEF;
        step();
        feed_valid = 1'b0;
        step();
        chk("mr_blk1", block_o, 16'hBEEF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_blk", block_o, 0);         chk("mr_bv", block_valid, 0);
        chk("mr_busy", busy, 0);           chk("mr_bl", block_last, 0);
        feed_valid = 1'b1; feed_data = 32'h01234567;
        step();
        feed_valid = 1'b0;
        chk("mr_new0", block_o, 16'h0123);
        step();
        chk("mr_new1", block_o, 16'h4567);

        // core_done outside WAIT_HASH -> ERROR
        do_reset();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("cd_err", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
